// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-add multiplier: operand widths, product width,
// rounding constant and the controller state encoding.
package shift_add_mult_pkg;

    localparam int Q_W         = 20;
    localparam int D_W         = 3;
    localparam int FRAC_W      = 10;
    localparam int P_W         = Q_W + D_W;
    localparam int ROUND_CONST = 'h200;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/shift_add_mult.sv
// Serial shift-add multiplier: unsigned Q10.10 quotient times a 3-bit integer, one bit per cycle.
// Define SHIFT_ADD_MULT_ROUND_EN to round the Q13.10 product half-up to an integer.
module shift_add_mult
    import shift_add_mult_pkg::*;
#(
    parameter int Q_W    = shift_add_mult_pkg::Q_W,
    parameter int D_W    = shift_add_mult_pkg::D_W,
    parameter int FRAC_W = shift_add_mult_pkg::FRAC_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [Q_W-1:0]       in_data_1,
    input  logic [D_W-1:0]       in_data_2,
    output logic                 out_valid,
    output logic [Q_W+D_W-1:0]   out_data
);

    localparam int P_W = Q_W + D_W;
    localparam logic [P_W-1:0] ROUND_ADD = P_W'(ROUND_CONST);
    localparam logic [P_W-1:0] KEEP_MASK = ~P_W'((1 << FRAC_W) - 1);

`ifdef SHIFT_ADD_MULT_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    state_t          state;
    logic [P_W-1:0]  acc;
    logic [Q_W-1:0]  multiplier;
    logic [P_W-1:0]  multiplicand;
    logic [P_W-1:0]  result;

    // Max product 0x6FFFF9 plus the half-LSB constant still fits in P_W bits.
    always_comb begin
        result = acc;
        if (ROUND_EN) begin
            result = (acc + ROUND_ADD) & KEEP_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            multiplier   <= '0;
            multiplicand <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state        <= LOAD;
                        multiplier   <= in_data_1;
                        multiplicand <= {{(P_W-D_W){1'b0}}, in_data_2};
                    end
                end
                // Operands are re-captured while in_valid stays high, so the last strobe cycle wins.
                LOAD: begin
                    if (in_valid) begin
                        multiplier   <= in_data_1;
                        multiplicand <= {{(P_W-D_W){1'b0}}, in_data_2};
                    end else begin
                        state <= MULT;
                        acc   <= '0;
                    end
                end
                MULT: begin
                    if (multiplier != '0) begin
                        if (multiplier[0]) begin
                            acc <= acc + multiplicand;
                        end
                        multiplier   <= multiplier >> 1;
                        multiplicand <= multiplicand << 1;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= result;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: directed corner cases, reset interruption and
// randomized operations checked against an arithmetic reference model.
module tb_shift_add_mult;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [19:0] in_data_1;
    logic [2:0]  in_data_2;
    logic        out_valid;
    logic [22:0] out_data;

    int pass_count;
    int total_count;

    shift_add_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected product straight from the arithmetic definition.
    function automatic logic [22:0] refProduct(input logic [19:0] q, input logic [2:0] d);
        int p;
        p = int'(q) * int'(d);
`ifdef SHIFT_ADD_MULT_ROUND_EN
        p = ((p + 512) / 1024) * 1024;
`endif
        return p[22:0];
    endfunction

    // Cycles from the LOAD->MULT edge to out_valid: bit-length of the quotient plus one.
    function automatic int refLatency(input logic [19:0] q);
        int b;
        b = 0;
        for (int i = 0; i < 20; i++) begin
            if (q[i]) b = i + 1;
        end
        return b + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Drives one operation (hold cycles of in_valid, last cycle carries q/d), optionally
    // toggles inputs during MULT, and measures latency, result and any stray output.
    task automatic applyStimulus(input logic [19:0] q, input logic [2:0] d, input int hold,
                                 input int noise_cycles, output int latency,
                                 output logic [22:0] data, output int stray);
        int  k;
        bit  done;
        stray   = 0;
        latency = 0;
        data    = '0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            if (i == hold - 1) begin
                in_data_1 = q;
                in_data_2 = d;
            end else begin
                in_data_1 = 20'($urandom);
                in_data_2 = 3'($urandom);
            end
            @(negedge clk);
            if (out_valid || out_data != '0) stray++;
        end
        in_valid  = 1'b0;
        in_data_1 = 20'($urandom);
        in_data_2 = 3'($urandom);
        k    = 0;
        done = 1'b0;
        while (!done && k <= 40) begin
            @(negedge clk);
            if (out_valid) begin
                latency = k;
                data    = out_data;
                done    = 1'b1;
            end else begin
                if (out_data != '0) stray++;
                if (k < noise_cycles) begin
                    in_valid  = 1'($urandom);
                    in_data_1 = 20'($urandom);
                    in_data_2 = 3'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
                k++;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        if (out_valid || out_data != '0) stray++;
    endtask

    task automatic runOp(input string tag, input logic [19:0] q, input logic [2:0] d,
                         input int hold, input int noise_cycles);
        int          latency;
        logic [22:0] data;
        int          stray;
        applyStimulus(q, d, hold, noise_cycles, latency, data, stray);
        checkOutput({tag, "_data"}, 32'(data), 32'(refProduct(q, d)));
        checkOutput({tag, "_latency"}, 32'(latency), 32'(refLatency(q)));
        checkOutput({tag, "_stray"}, 32'(stray), 32'd0);
    endtask

    initial begin
        int          stale;
        int          wait_cycles;
        logic [19:0] rq;
        logic [2:0]  rd;

        pass_count  = 0;
        total_count = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data_1   = '0;
        in_data_2   = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        runOp("exact_3x3", 20'h00C00, 3'd3, 1, 0);
        runOp("round_555x3", 20'h00555, 3'd3, 1, 0);
        runOp("max_operands", 20'hFFFFF, 3'd7, 1, 0);
        runOp("zero_quotient", 20'h00000, 3'd5, 1, 0);
        runOp("zero_divisor", 20'h12345, 3'd0, 1, 0);
        runOp("hold_4_cycles", 20'h0ABCD, 3'd6, 4, 0);
        runOp("noise_in_mult", 20'h80001, 3'd5, 1, 15);

        // Reset mid-MULT must kill the operation silently.
        in_valid  = 1'b1;
        in_data_1 = 20'hFFFFF;
        in_data_2 = 3'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midmult_reset_valid", 32'(out_valid), 32'd0);
        checkOutput("midmult_reset_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid || out_data != '0) stale++;
        end
        checkOutput("midmult_no_stale", 32'(stale), 32'd0);

        // Reset while the result is being presented clears the outputs at once.
        in_valid  = 1'b1;
        in_data_1 = 20'h00C00;
        in_data_2 = 3'd3;
        @(negedge clk);
        in_valid    = 1'b0;
        wait_cycles = 0;
        while (!out_valid && wait_cycles < 40) begin
            @(negedge clk);
            wait_cycles++;
        end
        checkOutput("done_seen_before_reset", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("done_reset_valid", 32'(out_valid), 32'd0);
        checkOutput("done_reset_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        runOp("after_reset_400x5", 20'h00400, 3'd5, 1, 0);

        for (int n = 0; n < 20; n++) begin
            rq = 20'($urandom);
            rd = 3'($urandom_range(0, 7));
            runOp($sformatf("random_%0d", n), rq, rd, $urandom_range(1, 4),
                  $urandom_range(0, refLatency(rq) - 1));
        end

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
